// File: rtl/tile_reg_responder.sv
// NoC target endpoint: single-beat register read/write with in-order responses via a small FIFO.
// Define TILE_REG_RESPONDER_ERR_EN to flag out-of-range word indices instead of wrapping them.
module tile_reg_responder #(
  parameter int unsigned NumRegs    = 8,
  parameter int unsigned IdWidth    = 8,
  parameter int unsigned TxnIdWidth = 4,
  parameter int unsigned RspDepth   = 2,
  parameter int unsigned AddrWidth  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IdWidth-1:0]      req_src_id_i,
  input  logic [TxnIdWidth-1:0]   req_txn_id_i,
  input  logic                    req_write_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [3:0]              req_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdWidth-1:0]      rsp_dst_id_o,
  output logic [TxnIdWidth-1:0]   rsp_txn_id_o,
  output logic                    rsp_write_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NumRegs*32-1:0]   regs_o,
  output logic                    busy_o
);

  localparam int unsigned RegIdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int unsigned PtrW    = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW    = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(RspDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);

  logic [31:0]           regs_q [NumRegs];
  logic [31:0]           regs_d [NumRegs];
  logic [IdWidth-1:0]    dst_q  [RspDepth];
  logic [IdWidth-1:0]    dst_d  [RspDepth];
  logic [TxnIdWidth-1:0] txn_q  [RspDepth];
  logic [TxnIdWidth-1:0] txn_d  [RspDepth];
  logic [31:0]           rdata_q[RspDepth];
  logic [31:0]           rdata_d[RspDepth];
  logic                  wr_q   [RspDepth];
  logic                  wr_d   [RspDepth];
  logic                  err_q  [RspDepth];
  logic                  err_d  [RspDepth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic               push, pop, addr_err, unused_addr;
  logic [RegIdxW-1:0] reg_idx;
  logic [31:0]        rd_val;

  // Ready is count-based only, and forced low while reset is asserted.
  assign req_ready_o = rst_ni && (cnt_q < DepthC);
  assign rsp_valid_o = (cnt_q != '0);
  assign busy_o      = rsp_valid_o;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign reg_idx     = req_addr_i[2 +: RegIdxW];

`ifdef TILE_REG_RESPONDER_ERR_EN
  assign addr_err    = |req_addr_i[AddrWidth-1:2+RegIdxW];
  assign unused_addr = ^req_addr_i[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_addr = ^{req_addr_i[AddrWidth-1:2+RegIdxW], req_addr_i[1:0]};
`endif

  assign rd_val = (req_write_i || addr_err) ? 32'h0 : regs_q[reg_idx];

  always_comb begin
    regs_d = regs_q;
    if (push && req_write_i && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb_i[b]) regs_d[reg_idx][8*b +: 8] = req_wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    dst_d    = dst_q;
    txn_d    = txn_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      dst_d[wr_ptr_q]   = req_src_id_i;
      txn_d[wr_ptr_q]   = req_txn_id_i;
      rdata_d[wr_ptr_q] = rd_val;
      wr_d[wr_ptr_q]    = req_write_i;
      err_d[wr_ptr_q]   = addr_err;
      wr_ptr_d          = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        dst_q[i]   <= '0;
        txn_q[i]   <= '0;
        rdata_q[i] <= '0;
        wr_q[i]    <= 1'b0;
        err_q[i]   <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      regs_q   <= regs_d;
      dst_q    <= dst_d;
      txn_q    <= txn_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data outputs read as zero whenever no response is pending.
  assign rsp_dst_id_o = rsp_valid_o ? dst_q[rd_ptr_q]   : '0;
  assign rsp_txn_id_o = rsp_valid_o ? txn_q[rd_ptr_q]   : '0;
  assign rsp_write_o  = rsp_valid_o && wr_q[rd_ptr_q];
  assign rsp_rdata_o  = rsp_valid_o ? rdata_q[rd_ptr_q] : '0;
  assign rsp_err_o    = rsp_valid_o && err_q[rd_ptr_q];

  for (genvar g = 0; g < NumRegs; g++) begin : gen_regs_o
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_tile_reg_responder.sv
// Directed self-checking bench for tile_reg_responder (default parameters).
module tb_tile_reg_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_src_id_i = '0;
  logic [3:0]  req_txn_id_i = '0;
  logic        req_write_i = 1'b0;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [7:0]  rsp_dst_id_o;
  logic [3:0]  rsp_txn_id_o;
  logic        rsp_write_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [255:0] regs_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  tile_reg_responder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src_id_i (req_src_id_i),
    .req_txn_id_i (req_txn_id_i),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wstrb_i  (req_wstrb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dst_id_o (rsp_dst_id_o),
    .rsp_txn_id_o (rsp_txn_id_o),
    .rsp_write_o  (rsp_write_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .regs_o       (regs_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a request at a negedge; it is accepted at the following posedge if ready.
  task automatic drive(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [7:0] src, input logic [3:0] txn);
    req_valid_i  = 1'b1;
    req_write_i  = wr;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_wstrb_i  = strb;
    req_src_id_i = src;
    req_txn_id_i = txn;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_o[32*i +: 32];
  endfunction

  initial begin
    // Reset state
    #12;
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_regs", regs_o[63:0], 0);
    check("rst_dst", rsp_dst_id_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_rst", req_ready_o, 1);

    // Basic write then read
    drive(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 8'h21, 4'd3);
    step();
    idle();
    check("wr_rsp_valid", rsp_valid_o, 1);
    check("wr_rsp_dst", rsp_dst_id_o, 8'h21);
    check("wr_rsp_txn", rsp_txn_id_o, 4'd3);
    check("wr_rsp_write", rsp_write_o, 1);
    check("wr_rsp_err", rsp_err_o, 0);
    check("wr_rsp_rdata", rsp_rdata_o, 0);
    check("wr_reg2", reg_at(2), 32'hDEADBEEF);
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h21, 4'd4);
    step();
    idle();
    check("rd_rsp_txn", rsp_txn_id_o, 4'd4);
    check("rd_rsp_write", rsp_write_o, 0);
    check("rd_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);
    step();
    check("drain_valid", rsp_valid_o, 0);

    // Byte strobes
    drive(1'b1, 12'h004, 32'h11223344, 4'hF, 8'h10, 4'd5);
    step();
    drive(1'b1, 12'h004, 32'hAABBCCDD, 4'h5, 8'h10, 4'd6);
    step();
    drive(1'b0, 12'h004, 32'h0, 4'h0, 8'h10, 4'd7);
    step();
    idle();
    check("strb_rdata", rsp_rdata_o, 32'h11BB33DD);
    check("strb_reg1", reg_at(1), 32'h11BB33DD);
    step();

    // Backpressure with a two-deep FIFO
    rsp_ready_i = 1'b0;
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h33, 4'd1);
    check("bp_ready0", req_ready_o, 1);
    step();
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h33, 4'd2);
    check("bp_ready1", req_ready_o, 1);
    step();
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h33, 4'd3);
    check("bp_full_ready", req_ready_o, 0);
    check("bp_head_txn", rsp_txn_id_o, 4'd1);
    check("bp_busy", busy_o, 1);
    step();
    check("bp_still_full", req_ready_o, 0);
    check("bp_head_stable", rsp_txn_id_o, 4'd1);
    rsp_ready_i = 1'b1;
    step();
    check("bp_ready_after_pop", req_ready_o, 1);
    check("bp_txn2", rsp_txn_id_o, 4'd2);
    step();
    idle();
    check("bp_txn3", rsp_txn_id_o, 4'd3);
    check("bp_txn3_rdata", rsp_rdata_o, 32'hDEADBEEF);
    step();
    check("bp_empty", rsp_valid_o, 0);
    check("bp_not_busy", busy_o, 0);

    // Back-to-back read-after-write at full throughput
    drive(1'b1, 12'h010, 32'h5, 4'hF, 8'h44, 4'd8);
    step();
    drive(1'b0, 12'h010, 32'h0, 4'h0, 8'h44, 4'd9);
    check("raw_ready", req_ready_o, 1);
    check("raw_wr_txn", rsp_txn_id_o, 4'd8);
    step();
    idle();
    check("raw_rd_txn", rsp_txn_id_o, 4'd9);
    check("raw_rdata", rsp_rdata_o, 32'h5);
    step();

    // Out-of-range index
    drive(1'b1, 12'h020, 32'h1234, 4'hF, 8'h55, 4'd10);
    step();
    idle();
    check("oor_txn", rsp_txn_id_o, 4'd10);
`ifdef TILE_REG_RESPONDER_ERR_EN
    check("oor_err", rsp_err_o, 1);
    check("oor_reg0", reg_at(0), 0);
`else
    check("oor_err", rsp_err_o, 0);
    check("oor_reg0", reg_at(0), 32'h1234);
`endif
    check("oor_reg2", reg_at(2), 32'hDEADBEEF);
    step();

    // Asynchronous reset with two responses pending
    rsp_ready_i = 1'b0;
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h66, 4'd11);
    step();
    drive(1'b0, 12'h004, 32'h0, 4'h0, 8'h66, 4'd12);
    step();
    idle();
    check("mid_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid_o, 0);
    check("mid_busy_clr", busy_o, 0);
    check("mid_regs_lo", regs_o[127:64], 0);
    check("mid_regs_hi", regs_o[191:128], 0);
    check("mid_ready", req_ready_o, 0);
    check("mid_txn", rsp_txn_id_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    drive(1'b0, 12'h008, 32'h0, 4'h0, 8'h77, 4'd13);
    step();
    idle();
    check("post_rst_txn", rsp_txn_id_o, 4'd13);
    check("post_rst_rdata", rsp_rdata_o, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_reg_responder.md
Name: tile_reg_responder

Overview:
- NoC-side target endpoint for a tile's narrow request link: accepts single-beat read/write request flits from remote initiators (cluster, Cheshire, SPU tiles) and returns one response flit per request, routed back to the requester's mesh id.
- Holds a small word-addressed register file, used as the tile's control/status target.
- Sits between the tile's router local port and tile-local control logic, which sees the register contents on a flat output.

Parameters:
- NumRegs, 8, number of 32-bit registers; power of two, ≥2.
- IdWidth, 8, width of the mesh id field ({x,y} packed).
- TxnIdWidth, 4, width of the transaction id echoed in responses.
- RspDepth, 2, response FIFO depth; ≥1.
- AddrWidth, 12, byte-address width of the request offset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request flit valid
- req_ready_o  out  1  request flit accepted when high with valid
- req_src_id_i  in  IdWidth  requester mesh id
- req_txn_id_i  in  TxnIdWidth  requester transaction id
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrWidth  byte offset within tile register space
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte enables for writes
- rsp_valid_o  out  1  response flit valid
- rsp_ready_i  in  1  router accepts response
- rsp_dst_id_o  out  IdWidth  equals the captured req_src_id_i
- rsp_txn_id_o  out  TxnIdWidth  echoed transaction id
- rsp_write_o  out  1  echoes request type
- rsp_rdata_o  out  32  read data; 0 for writes
- rsp_err_o  out  1  access error
- regs_o  out  NumRegs*32  current register contents, register 0 in the LSBs
- busy_o  out  1  high when the response FIFO is non-empty

Behaviour:
- Reset: all registers 0, FIFO empty, rsp_valid_o=0, busy_o=0, req_ready_o=0 while rst_ni low, and all rsp_* data outputs 0.
- Handshake: transfer on valid&&ready, on both channels.
  - req_ready_o = (fifo_count < RspDepth).
  - req_ready_o is registered/count-based only; it has no combinational path from rsp_ready_i.
  - rsp_valid_o, once high, stays high with stable data until rsp_ready_i.
- Index: word index = req_addr_i[AddrWidth-1:2]. Bits [1:0] are ignored.
- Write accepted in cycle N:
  - Each byte is updated where wstrb is 1, at the clock edge ending cycle N.
  - regs_o shows the new value in cycle N+1.
- Read accepted in cycle N: returns the register value as of cycle N, including any write accepted in an earlier cycle.
- Latency: a request accepted in cycle N makes its response visible on rsp_* in cycle N+1 at the earliest (registered FIFO output, no fall-through).
- Ordering: responses leave in strict request order (FIFO).
- FIFO boundaries:
  - Full (count==RspDepth): req_ready_o=0. A pop in the same cycle does not reopen the request port until the next cycle.
  - Empty: rsp_valid_o=0.
  - Push and pop in the same cycle at a non-full, non-empty count: count unchanged, ordering kept.
  - Pointers wrap modulo RspDepth.
- Reset mid-operation: all pending responses are discarded, registers clear, and outputs return to reset values immediately (asynchronous).
- busy_o = (fifo_count != 0).

Optional Feature:
- Macro: TILE_REG_RESPONDER_ERR_EN
- Defined:
  - A word index ≥ NumRegs is an error: rsp_err_o=1, rsp_rdata_o=0, and a write does not modify any register.
  - A write with wstrb==0 is legal (no-op, err=0).
- Undefined:
  - The index wraps modulo NumRegs (low log2(NumRegs) bits used).
  - rsp_err_o is tied 0.

Test Plan:
- Basic write/read: write addr 0x008, wdata 0xDEADBEEF, strb 0xF, src 0x21, txn 3.
  - Write response in the next cycle: dst 0x21, txn 3, write=1, err=0.
  - regs_o[2] = 0xDEADBEEF.
  - Read of 0x008 returns 0xDEADBEEF.
- Byte strobes: reg 1 = 0x11223344, then write 0xAABBCCDD with strb 0x5 → read returns 0x11BB33DD.
- Backpressure, RspDepth=2, rsp_ready_i=0:
  - Issue 3 requests with txn 1, 2, 3. Two are accepted, then req_ready_o=0.
  - Raise rsp_ready_i: responses come out with txn 1, 2, 3 in order.
  - req_ready_o rises one cycle after the first pop.
- Back-to-back RAW: write reg 4 = 0x5 at cycle N, read reg 4 at cycle N+1 → rdata 0x5. Throughput is 1 req/cycle with rsp_ready_i held 1.
- Out of range, NumRegs=8, write addr 0x020 with 0x1234:
  - With the macro defined: err=1 and regs unchanged.
  - Without the macro: err=0, and reg 0 = 0x1234.
- Mid-operation reset: deassert rst_ni with 2 responses pending → rsp_valid_o=0, busy_o=0, and regs_o all 0 asynchronously. After release, a read of reg 2 returns 0.
